// File: rtl/adder_tree_ich_acc_pkg.sv
// Shared accumulator helpers: state encodings, clog2 and a saturating clip
// used by the adder-tree accumulator and the output quantiser.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clip a wide signed value into the signed range of a w-bit word (w <= 64).
  function automatic logic signed [64:0] sat_s(input logic signed [64:0] x, input int unsigned w);
    logic signed [64:0] hi, lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/adder_tree_ich_acc_level.sv
// One adder-tree level: N_IN/2 pairwise wrapping adds, optionally registered
// with a valid bit and a load enable.
module adder_tree_level #(
  parameter int W    = 32,
  parameter int N_IN = 2,
  parameter bit REG  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_vld,
  input  logic [N_IN-1:0][W-1:0]       in_d,
  output logic                         out_vld,
  output logic [N_IN/2-1:0][W-1:0]     out_d
);

  logic [N_IN/2-1:0][W-1:0] sum;

  always_comb begin
    for (int i = 0; i < N_IN / 2; i++) sum[i] = in_d[2*i] + in_d[2*i+1];
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld <= 1'b0;
        out_d   <= '0;
      end else if (en) begin
        out_vld <= in_vld;
        out_d   <= sum;
      end
    end
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign out_vld   = in_vld;
    assign out_d     = sum;
  end

endmodule

// File: rtl/adder_tree_ich_acc.sv
// Pipelined signed adder tree over NUM_CH channels, accumulated over cfg_grp_num groups.
// Optional ADDER_TREE_ACC_SAT_EN: saturating accumulator with sticky out_sat.
module adder_tree_ich_acc
  import acc_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_CH      = 32,
  parameter int PSUM_WIDTH  = 32,
  parameter int LVL_PER_REG = 2,
  parameter int GRP_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GRP_W-1:0]              cfg_grp_num,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH*NUM_CH-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [PSUM_WIDTH-1:0]  out_psum,
`ifdef ADDER_TREE_ACC_SAT_EN
  output logic                          out_sat,
`endif
  output logic                          busy
);

  localparam int LEVELS = clog2(NUM_CH);

  logic                                 pipe_en;
  logic [LEVELS:0]                      vld_pipe;
  logic [LEVELS-1:0]                    reg_vld;
  logic [NUM_CH-1:0][PSUM_WIDTH-1:0]    in_ext;
  logic signed [PSUM_WIDTH-1:0]         tree_d, acc, acc_nxt;
  logic [GRP_W-1:0]                     cnt, n_lat, cfg_n;
  logic                                 do_start, do_acc;
  acc_st_e                              state;

  // Single global stall: the whole pipe freezes while a result waits downstream.
  assign pipe_en     = !(out_valid && !out_ready);
  assign in_ready    = pipe_en && !rst;
  assign vld_pipe[0] = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      in_ext[k] = PSUM_WIDTH'($signed(in_data[k*IN_WIDTH +: IN_WIDTH]));
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = NUM_CH >> l;
    localparam bit RG = (((l + 1) % LVL_PER_REG) == 0) || (l == LEVELS - 1);
    logic [NI-1:0][PSUM_WIDTH-1:0]   din;
    logic [NI/2-1:0][PSUM_WIDTH-1:0] dout;
    if (l == 0) begin : g_src
      assign din = in_ext;
    end else begin : g_src
      assign din = g_lvl[l-1].dout;
    end
    adder_tree_level #(.W(PSUM_WIDTH), .N_IN(NI), .REG(RG)) u_lvl (
      .clk     (clk),
      .rst     (rst),
      .en      (pipe_en),
      .in_vld  (vld_pipe[l]),
      .in_d    (din),
      .out_vld (vld_pipe[l+1]),
      .out_d   (dout)
    );
    assign reg_vld[l] = RG ? vld_pipe[l+1] : 1'b0;
  end

  assign tree_d = g_lvl[LEVELS-1].dout[0];
  assign cfg_n  = (cfg_grp_num == '0) ? GRP_W'(1) : cfg_grp_num;

  // A tree beat either opens a set (idle, or hold being drained) or extends one.
  assign do_start = vld_pipe[LEVELS] && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  assign do_acc   = vld_pipe[LEVELS] && (state == ST_ACCUM);

`ifdef ADDER_TREE_ACC_SAT_EN
  logic signed [64:0] sum_w, sum_s;
  logic               clip, sat_q;

  always_comb begin
    sum_w   = 65'(acc) + 65'(tree_d);
    sum_s   = sat_s(sum_w, PSUM_WIDTH);
    acc_nxt = sum_s[PSUM_WIDTH-1:0];
    clip    = (sum_s != sum_w);
  end

  always_ff @(posedge clk) begin
    if (rst)           sat_q <= 1'b0;
    else if (do_start) sat_q <= 1'b0;
    else if (do_acc)   sat_q <= sat_q | clip;
  end
  assign out_sat = sat_q;
`else
  assign acc_nxt = acc + tree_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      n_lat <= '0;
    end else if (do_start) begin
      acc   <= tree_d;
      cnt   <= GRP_W'(1);
      n_lat <= cfg_n;
      state <= (cfg_n == GRP_W'(1)) ? ST_HOLD : ST_ACCUM;
    end else if (do_acc) begin
      acc <= acc_nxt;
      cnt <= cnt + GRP_W'(1);
      if ((cnt + GRP_W'(1)) == n_lat) state <= ST_HOLD;
    end else if ((state == ST_HOLD) && out_ready) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign out_psum  = acc;
  assign busy      = (|reg_vld) || (state != ST_IDLE);

endmodule

// File: tb/tb_adder_tree_ich_acc.sv
// Directed + randomized bench for adder_tree_ich_acc: a default-parameter instance
// checked against a group-sum scoreboard, and a narrow 8-channel instance for wrap/saturation.
module tb_adder_tree_ich_acc;

  localparam int W1 = 16, C1 = 32, P1 = 32, L1 = 2;
  localparam int W2 = 20, C2 = 8,  P2 = 24, L2 = 3;
  localparam int LAT1 = ($clog2(C1) + L1 - 1) / L1 + 1;
  localparam int LAT2 = ($clog2(C2) + L2 - 1) / L2 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]              cfg1, cfg2;
  logic                    iv1, ir1, ov1, or1, busy1, sat1;
  logic [C1*W1-1:0]        id1;
  logic signed [P1-1:0]    op1;
  logic                    iv2, ir2, ov2, or2, busy2, sat2;
  logic [C2*W2-1:0]        id2;
  logic signed [P2-1:0]    op2;

  adder_tree_ich_acc #(.IN_WIDTH(W1), .NUM_CH(C1), .PSUM_WIDTH(P1), .LVL_PER_REG(L1), .GRP_W(8)) dut1 (
    .clk(clk), .rst(rst), .cfg_grp_num(cfg1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_psum(op1),
`ifdef ADDER_TREE_ACC_SAT_EN
    .out_sat(sat1),
`endif
    .busy(busy1));

  adder_tree_ich_acc #(.IN_WIDTH(W2), .NUM_CH(C2), .PSUM_WIDTH(P2), .LVL_PER_REG(L2), .GRP_W(8)) dut2 (
    .clk(clk), .rst(rst), .cfg_grp_num(cfg2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_psum(op2),
`ifdef ADDER_TREE_ACC_SAT_EN
    .out_sat(sat2),
`endif
    .busy(busy2));

`ifndef ADDER_TREE_ACC_SAT_EN
  assign sat1 = 1'b0;
  assign sat2 = 1'b0;
`endif

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint wrapw(input longint v, input int w);
    logic [63:0] u;
    u = v;
    u = u & ((64'd1 << w) - 64'd1);
    if (u[w-1]) return longint'(u) - (longint'(1) << w);
    return longint'(u);
  endfunction

  function automatic longint bsum1(input logic [C1*W1-1:0] d);
    longint s = 0;
    for (int k = 0; k < C1; k++) s += longint'($signed(d[k*W1 +: W1]));
    return s;
  endfunction

  function automatic longint bsum2(input logic [C2*W2-1:0] d);
    longint s = 0;
    for (int k = 0; k < C2; k++) s += longint'($signed(d[k*W2 +: W2]));
    return s;
  endfunction

  function automatic logic [C1*W1-1:0] fill1(input int v);
    logic [C1*W1-1:0] r;
    for (int k = 0; k < C1; k++) r[k*W1 +: W1] = W1'(v);
    return r;
  endfunction

  function automatic logic [C2*W2-1:0] fill2(input int v);
    logic [C2*W2-1:0] r;
    for (int k = 0; k < C2; k++) r[k*W2 +: W2] = W2'(v);
    return r;
  endfunction

  function automatic logic [C1*W1-1:0] rnd1();
    logic [C1*W1-1:0] r;
    for (int k = 0; k < C1*W1/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [C2*W2-1:0] rnd2_small();
    logic [C2*W2-1:0] r;
    for (int k = 0; k < C2; k++) r[k*W2 +: W2] = W2'(int'($urandom_range(0, 262143)) - 131072);
    return r;
  endfunction

  // Accumulate one set of beats for dut2 following the update rules (first beat loads).
  function automatic longint set2(input logic [C2*W2-1:0] b0, b1, b2, b3, input int n, output logic clipped);
    longint a, s, hi, lo;
    logic [C2*W2-1:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    hi = (longint'(1) << (P2 - 1)) - 1;
    lo = -(longint'(1) << (P2 - 1));
    clipped = 1'b0;
    a = 0;
    for (int i = 0; i < n; i++) begin
      s = bsum2(bs[i]);
      if (i == 0) a = s;
      else begin
        a = a + s;
`ifdef ADDER_TREE_ACC_SAT_EN
        if (a > hi) begin a = hi; clipped = 1'b1; end
        if (a < lo) begin a = lo; clipped = 1'b1; end
`else
        a = wrapw(a, P2);
`endif
      end
    end
    return a;
  endfunction

  longint m_sum;
  int     m_cnt = 0, m_n = 1, npop = 0;
  longint expq[$];
  logic   last_ov, last_acc, last_ov2;

  task automatic model_accept1(input logic [C1*W1-1:0] d);
    if (m_cnt == 0) begin
      m_n   = (cfg1 == 0) ? 1 : int'(cfg1);
      m_sum = 0;
    end
    m_sum += bsum1(d);
    m_cnt++;
    if (m_cnt == m_n) begin
      expq.push_back(wrapw(m_sum, P1));
      m_cnt = 0;
    end
  endtask

  // One cycle of dut1: sample away from the edge, score handshakes, then advance.
  task automatic tick1();
    @(negedge clk);
    chk("in_ready_rule", ir1, !(ov1 && !or1) && !rst);
    if (ov1 && or1) begin
      if (expq.size() == 0) chk("spurious_out", ov1, 1'b0);
      else begin
        chk("out_psum", op1, expq.pop_front());
        npop++;
      end
    end
    last_acc = iv1 && ir1;
    if (last_acc) model_accept1(id1);
    last_ov = ov1;
    @(posedge clk); #1;
  endtask

  task automatic send1(input logic [C1*W1-1:0] d);
    iv1 = 1'b1; id1 = d;
    tick1();
    iv1 = 1'b0;
  endtask

  task automatic wait1(output int lat);
    or1 = 1'b0;
    lat = 0;
    do begin tick1(); lat++; end while (!last_ov && lat < 40);
  endtask

  task automatic single1(input logic [C1*W1-1:0] d, input logic [7:0] cfg, input longint exp, input string tag);
    int lat;
    cfg1 = cfg;
    send1(d);
    wait1(lat);
    chk({tag, "_latency"}, lat, LAT1);
    chk({tag, "_value"}, op1, exp);
    chk({tag, "_sat"}, sat1, 1'b0);
    or1 = 1'b1;
    tick1();
    tick1();
  endtask

  task automatic tick2();
    @(negedge clk);
    last_ov2 = ov2;
    @(posedge clk); #1;
  endtask

  task automatic wait2(output int lat);
    or2 = 1'b0;
    lat = 0;
    do begin tick2(); lat++; end while (!last_ov2 && lat < 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n, cyc, pop0;
    logic clipped;
    longint e;
    logic [C1*W1-1:0] ramp;
    logic [C2*W2-1:0] a2, b2, mx;

    rst = 1'b1; cfg1 = 8'd1; cfg2 = 8'd1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b1;
    iv2 = 1'b0; id2 = '0; or2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_in_ready", ir1, 1'b0);
    chk("rst_out_psum", op1, 0);
    chk("rst_out_valid2", ov2, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single-beat sets
    single1(fill1(1), 8'd1, 32, "ones");
    for (int k = 0; k < C1; k++) ramp[k*W1 +: W1] = W1'(-k);
    single1(ramp, 8'd1, -496, "ramp");
    single1(fill1(-32768), 8'd1, -1048576, "negmax");
    single1(fill1(5), 8'd0, 160, "grp0");

    // three-group set, no output until the last group lands
    cfg1 = 8'd3; or1 = 1'b1;
    send1(fill1(2));
    repeat (6) tick1();
    chk("grp3_no_out_1", ov1, 1'b0);
    send1(fill1(3));
    repeat (6) tick1();
    chk("grp3_no_out_2", ov1, 1'b0);
    send1(fill1(-1));
    wait1(lat);
    chk("grp3_latency", lat, LAT1);
    chk("grp3_value", op1, 128);
    or1 = 1'b1;
    tick1();

    // back-to-back streams under backpressure
    for (int pass = 0; pass < 2; pass++) begin
      cfg1 = (pass == 0) ? 8'd2 : 8'd3;
      pop0 = npop;
      n = 0; cyc = 0;
      iv1 = 1'b1; id1 = rnd1();
      while (n < 18 && cyc < 400) begin
        or1 = (pass == 0) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
        tick1();
        if (last_acc) begin n++; id1 = rnd1(); end
        cyc++;
      end
      iv1 = 1'b0;
      chk("b2b_beats", n, 18);
      or1 = 1'b1; cyc = 0;
      while ((expq.size() != 0 || busy1) && cyc < 60) begin tick1(); cyc++; end
      chk("b2b_drained", expq.size(), 0);
      chk("b2b_outputs", npop - pop0, (pass == 0) ? 9 : 6);
    end

    // reset in the middle of a set discards the partial sum
    cfg1 = 8'd4;
    send1(rnd1());
    send1(rnd1());
    rst = 1'b1;
    tick1();
    rst = 1'b0;
    m_cnt = 0; expq.delete();
    chk("midrst_out_valid", ov1, 1'b0);
    chk("midrst_busy", busy1, 1'b0);
    send1(fill1(7)); send1(fill1(8)); send1(fill1(9)); send1(fill1(10));
    wait1(lat);
    chk("midrst_latency", lat, LAT1);
    chk("midrst_value", op1, 1088);
    or1 = 1'b1;
    tick1(); tick1();
    chk("midrst_queue", expq.size(), 0);

    // narrow instance: latency, random set, stall hold
    cfg2 = 8'd2;
    a2 = rnd2_small(); b2 = rnd2_small();
    iv2 = 1'b1; id2 = a2; tick2();
    id2 = b2; tick2();
    iv2 = 1'b0;
    wait2(lat);
    e = set2(a2, b2, '0, '0, 2, clipped);
    chk("n8_latency", lat, LAT2);
    chk("n8_value", op2, e);
    chk("n8_stall_ready", ir2, 1'b0);
    chk("n8_sat", sat2, clipped);
    or2 = 1'b1;
    tick2(); tick2();
    chk("n8_consumed", ov2, 1'b0);

    // near-max beats: wrap or saturate depending on the build
    cfg2 = 8'd4;
    mx = fill2(524287);
    for (int i = 0; i < 4; i++) begin iv2 = 1'b1; id2 = mx; tick2(); end
    iv2 = 1'b0;
    wait2(lat);
    e = set2(mx, mx, mx, mx, 4, clipped);
    chk("nearmax_value", op2, e);
    chk("nearmax_sat", sat2, clipped);
    or2 = 1'b1;
    tick2();

    // a clean set afterwards must clear the sticky flag
    cfg2 = 8'd1;
    a2 = rnd2_small();
    iv2 = 1'b1; id2 = a2; tick2();
    iv2 = 1'b0;
    wait2(lat);
    e = set2(a2, '0, '0, '0, 1, clipped);
    chk("clean_latency", lat, LAT2);
    chk("clean_value", op2, e);
    chk("clean_sat", sat2, clipped);
    or2 = 1'b1;
    tick2(); tick2();
    chk("final_busy2", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
